// File: rtl/clk_gen_multi_pkg.sv
// ============================================================================
// clk_gen_multi_pkg : mode encodings and tap-event helper shared by clk_gen_multi
// Revision: 1.0
// ============================================================================
`default_nettype none

package clk_gen_multi_pkg;

    typedef enum logic [1:0] {
        MODE_FAST = 2'b00,
        MODE_SLOW = 2'b01,
        MODE_STEP = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    localparam int TAP_IDX_W = 6;
    // Counters are zero-extended to this width so any 6-bit tap index is legal.
    localparam int TAP_CNT_W = 64;

    // True when cnt[tap] is set and every bit below it is clear.
    function automatic logic tap_event(input logic [TAP_CNT_W-1:0] cnt,
                                       input logic [TAP_IDX_W-1:0] tap);
        logic [TAP_CNT_W-1:0] bit_mask;
        bit_mask = TAP_CNT_W'(1) << tap;
        return ((cnt & bit_mask) != '0) &&
               ((cnt & (bit_mask - TAP_CNT_W'(1))) == '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_gen_multi_btn_debounce.sv
// ============================================================================
// btn_debounce : 2-flop synchroniser, stability counter, debounced level and
//                one-cycle rising-edge pulse for a bouncy push-button
// Revision: 1.0
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DB_LEN = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CTR_W = (DB_LEN > 1) ? $clog2(DB_LEN) : 1;
    localparam logic [CTR_W-1:0] C_CNT_LAST = CTR_W'(DB_LEN - 1);

    logic [1:0]       r_sync;
    logic [CTR_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             w_in;

    assign w_in = r_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], btn};
            r_rise <= 1'b0;
            // Any cycle agreeing with the current level restarts the stability run.
            if (w_in == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= w_in;
                r_rise  <= w_in;
            end else begin
                r_cnt <= r_cnt + CTR_W'(1);
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

`default_nettype wire

// File: rtl/clk_gen_multi.sv
// ============================================================================
// clk_gen_multi : free-running divider, tap-selectable tick channels and a
//                 four-mode CPU clock with glitch-free mode switching
// Revision: 1.0
// ============================================================================
`default_nettype none

module clk_gen_multi
    import clk_gen_multi_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int N_CH     = 4,
    parameter int FAST_TAP = 2,
    parameter int SLOW_TAP = 24,
    parameter int DB_LEN   = 1000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                mode,
    input  logic                      step_btn,
    input  logic [N_CH*TAP_IDX_W-1:0] ch_sel,
    output logic [CNT_W-1:0]          clkdiv,
    output logic [N_CH-1:0]           ch_tick,
    output logic                      cpu_clk,
    output logic                      cpu_ce,
    output logic [1:0]                cur_mode
);

    localparam int STEP_W = FAST_TAP + 1;
    localparam logic [STEP_W-1:0]    C_STEP_LAST = STEP_W'((1 << FAST_TAP) - 1);
    localparam logic [TAP_IDX_W-1:0] C_FAST_TAP  = TAP_IDX_W'(FAST_TAP);
    localparam logic [TAP_IDX_W-1:0] C_SLOW_TAP  = TAP_IDX_W'(SLOW_TAP);

    logic [CNT_W-1:0]     r_clkdiv;
    logic [TAP_CNT_W-1:0] w_cnt_ext;
    logic [N_CH-1:0]      r_tick;
    logic [N_CH-1:0]      w_tick_nxt;

    logic [1:0]           r_mode_s1;
    logic [1:0]           r_mode_s2;
    mode_e                w_req;
    mode_e                r_state;
    mode_e                w_state_nxt;
    mode_e                r_pend_mode;
    mode_e                w_pend_mode_nxt;
    logic                 r_pend_vld;
    logic                 w_pend_vld_nxt;
    logic                 w_commit;

    logic                 r_cpu_clk;
    logic                 r_cpu_ce;
    logic                 r_armed;
    logic [STEP_W-1:0]    r_step_left;
    logic [TAP_IDX_W-1:0] w_tap;
    logic                 w_tap_lvl;
    logic                 w_tap_ev;
    logic                 w_step_level;
    logic                 w_step_rise;

    assign w_cnt_ext = TAP_CNT_W'(r_clkdiv);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clkdiv <= '0;
        end else begin
            r_clkdiv <= r_clkdiv + CNT_W'(1);
        end
    end

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            logic [TAP_IDX_W-1:0] w_sel;
            assign w_sel = ch_sel[i*TAP_IDX_W +: TAP_IDX_W];
            assign w_tick_nxt[i] = (int'(w_sel) < CNT_W) && tap_event(w_cnt_ext, w_sel);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick <= '0;
        end else begin
            r_tick <= w_tick_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_s1 <= '0;
            r_mode_s2 <= '0;
        end else begin
            r_mode_s1 <= mode;
            r_mode_s2 <= r_mode_s1;
        end
    end

    assign w_req = mode_e'(r_mode_s2);

    btn_debounce #(
        .DB_LEN (DB_LEN)
    ) u_step_db (
        .clk   (clk),
        .rst   (rst),
        .btn   (step_btn),
        .level (w_step_level),
        .rise  (w_step_rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= MODE_FAST;
            r_pend_mode <= MODE_FAST;
            r_pend_vld  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend_mode <= w_pend_mode_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
        end
    end

    // A pending mode only takes over while the CPU clock is low.
    always_comb begin
        w_state_nxt     = r_state;
        w_pend_mode_nxt = r_pend_mode;
        w_pend_vld_nxt  = r_pend_vld;
        w_commit        = r_pend_vld && !r_cpu_clk;
        if (w_commit) begin
            w_state_nxt    = r_pend_mode;
            w_pend_vld_nxt = 1'b0;
        end else if (w_req != r_state) begin
            w_pend_vld_nxt  = 1'b1;
            w_pend_mode_nxt = w_req;
        end else begin
            w_pend_vld_nxt = 1'b0;
        end
    end

    assign w_tap     = (r_state == MODE_SLOW) ? C_SLOW_TAP : C_FAST_TAP;
    assign w_tap_lvl = w_cnt_ext[w_tap];
    assign w_tap_ev  = tap_event(w_cnt_ext, w_tap);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpu_clk   <= 1'b0;
            r_cpu_ce    <= 1'b0;
            r_armed     <= 1'b0;
            r_step_left <= '0;
        end else begin
            r_cpu_ce <= 1'b0;
            if (w_commit) begin
                r_cpu_clk <= 1'b0;
                r_armed   <= 1'b0;
            end else begin
                case (r_state)
                    MODE_FAST, MODE_SLOW: begin
                        // Stay low until the tap rises so the first high phase is full length.
                        if (r_armed || w_tap_ev) begin
                            r_armed   <= 1'b1;
                            r_cpu_clk <= w_tap_lvl;
                            r_cpu_ce  <= w_tap_ev;
                        end else begin
                            r_cpu_clk <= 1'b0;
                        end
                    end
                    MODE_STEP: begin
                        if (r_cpu_clk) begin
                            if (r_step_left == '0) begin
                                r_cpu_clk <= 1'b0;
                            end else begin
                                r_step_left <= r_step_left - STEP_W'(1);
                            end
                        end else if (w_step_rise && w_step_level) begin
                            r_cpu_clk   <= 1'b1;
                            r_cpu_ce    <= 1'b1;
                            r_step_left <= C_STEP_LAST;
                        end
                    end
                    default: begin
                        r_cpu_clk <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign clkdiv   = r_clkdiv;
    assign ch_tick  = r_tick;
    assign cpu_clk  = r_cpu_clk;
    assign cpu_ce   = r_cpu_ce;
    assign cur_mode = r_state;

endmodule

`default_nettype wire

// File: tb/tb_clk_gen_multi.sv
// ============================================================================
// tb_clk_gen_multi : self-checking bench for clk_gen_multi (small parameters)
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_clk_gen_multi;

    localparam int CNT_W    = 8;
    localparam int N_CH     = 2;
    localparam int FAST_TAP = 1;
    localparam int SLOW_TAP = 4;
    localparam int DB_LEN   = 4;
    localparam int SEL0     = 3;
    localparam int SEL1     = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        mode = 2'b00;
    logic              step_btn = 1'b0;
    logic [N_CH*6-1:0] ch_sel = {6'(SEL1), 6'(SEL0)};
    logic [CNT_W-1:0]  clkdiv;
    logic [N_CH-1:0]   ch_tick;
    logic              cpu_clk;
    logic              cpu_ce;
    logic [1:0]        cur_mode;

    clk_gen_multi #(
        .CNT_W    (CNT_W),
        .N_CH     (N_CH),
        .FAST_TAP (FAST_TAP),
        .SLOW_TAP (SLOW_TAP),
        .DB_LEN   (DB_LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .step_btn (step_btn),
        .ch_sel   (ch_sel),
        .clkdiv   (clkdiv),
        .ch_tick  (ch_tick),
        .cpu_clk  (cpu_clk),
        .cpu_ce   (cpu_ce),
        .cur_mode (cur_mode)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         n_tick0 = 0;
    int         hi_len = 0;
    logic       prev_clk = 1'b0;
    logic [7:0] m_cnt;
    int         q_tick0[$];
    int         q_step[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit tb_tap(input int cnt, input int t);
        if (t >= CNT_W) return 1'b0;
        return (cnt % (2 << t)) == (1 << t);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) m_cnt <= '0;
        else     m_cnt <= m_cnt + 8'd1;
    end

    // Continuous monitor: counter, tick scoreboard, cpu_ce/cpu_clk relation, step pulse scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            q_tick0.delete();
            q_step.delete();
            prev_clk = 1'b0;
            hi_len   = 0;
        end else begin
            check_eq("clkdiv", clkdiv, m_cnt);
            if (ch_tick[0]) begin
                n_tick0++;
                if (q_tick0.size() == 0) check_eq("tick0_unexp", 1, 0);
                else                     check_eq("tick0_cyc", cyc, q_tick0.pop_front());
            end else if (q_tick0.size() != 0 && q_tick0[0] < cyc) begin
                check_eq("tick0_miss", cyc, q_tick0.pop_front());
            end
            if (ch_tick[1]) check_eq("tick1_unexp", 1, 0);
            if (tb_tap(int'(m_cnt), SEL0)) q_tick0.push_back(cyc + 1);
            if (cpu_ce || (cpu_clk && !prev_clk))
                check_eq("ce_first_high", cpu_ce, cpu_clk && !prev_clk);
            if (cpu_clk) begin
                hi_len++;
            end else if (prev_clk) begin
                if (cur_mode == 2'b10) begin
                    if (q_step.size() == 0) check_eq("step_unexp", 1, 0);
                    else                    check_eq("step_len", hi_len, q_step.pop_front());
                end
                hi_len = 0;
            end
            prev_clk = cpu_clk;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, first, len, t0;
        logic seen_low;

        repeat (3) @(negedge clk);
        check_eq("rst_clkdiv", clkdiv, 0);
        check_eq("rst_tick", ch_tick, 0);
        check_eq("rst_cpu_clk", cpu_clk, 0);
        check_eq("rst_cpu_ce", cpu_ce, 0);
        check_eq("rst_mode", cur_mode, 0);
        #1 rst = 1'b0;

        // FAST from reset: 2 high / 2 low, counter wraps at 256
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            check_eq("fast_cnt", clkdiv, i % 256);
            check_eq("fast_clk", cpu_clk, (i >= 3) ? ((i - 1) >> 1) & 1 : 0);
            if (cpu_ce) n++;
            if (i % 50 == 0) check_eq("fast_mode", cur_mode, 0);
        end
        check_eq("fast_ce_cnt", n, 75);

        // FAST -> SLOW requested while cpu_clk is high
        mode = 2'b01;
        seen_low = 1'b0;
        t0 = 0;
        while (cur_mode == 2'b00 && t0 < 20) begin
            seen_low |= !cpu_clk;
            @(negedge clk);
            t0++;
        end
        check_eq("slow_commit", cur_mode, 1);
        check_eq("slow_after_fall", seen_low, 1);
        t0 = 0;
        while (!cpu_ce && t0 < 64) begin
            check_eq("slow_no_runt", cpu_clk, 0);
            @(negedge clk);
            t0++;
        end
        check_eq("slow_ce_seen", cpu_ce, 1);
        len = 0;
        while (cpu_clk && len < 40) begin
            len++;
            @(negedge clk);
        end
        check_eq("slow_hi_len", len, 16);
        t0 = 0;
        while (!cpu_clk && t0 < 40) begin
            t0++;
            @(negedge clk);
        end
        check_eq("slow_lo_len", t0, 16);
        check_eq("slow_ce2", cpu_ce, 1);

        // SLOW -> FAST requested at the start of a 16-cycle high phase
        mode = 2'b00;
        t0 = 0;
        while (cpu_clk && t0 < 40) begin
            check_eq("slow_hold_mode", cur_mode, 1);
            @(negedge clk);
            t0++;
        end
        @(negedge clk);
        check_eq("fast_commit", cur_mode, 0);

        // STEP mode
        mode = 2'b10;
        t0 = 0;
        while (cur_mode != 2'b10 && t0 < 20) begin
            @(negedge clk);
            t0++;
        end
        check_eq("step_commit", cur_mode, 2);
        repeat (8) @(negedge clk);
        step_btn = 1'b1;
        repeat (2) @(negedge clk);
        step_btn = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cpu_ce) n++;
        end
        check_eq("glitch_ce", n, 0);

        q_step.push_back(1 << FAST_TAP);
        step_btn = 1'b1;
        n = 0;
        first = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (cpu_ce) begin
                n++;
                if (first < 0) first = k;
            end
            if (first >= 0 && k == first + 1) step_btn = 1'b0;       // re-press during pulse
            else if (first >= 0 && k == first + 2) step_btn = 1'b1;
            if (k == 12) step_btn = 1'b0;
        end
        check_eq("step_ce_cnt", n, 1);
        check_eq("step_lat", (first >= 1 && first <= 12), 1);
        check_eq("step_done", q_step.size(), 0);

        // HOLD while a press completes
        mode = 2'b11;
        t0 = 0;
        while (cur_mode != 2'b11 && t0 < 20) begin
            @(negedge clk);
            t0++;
        end
        check_eq("hold_commit", cur_mode, 3);
        step_btn = 1'b1;
        t0 = n_tick0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            check_eq("hold_out", {cpu_clk, cpu_ce}, 0);
        end
        check_eq("hold_ticks", (n_tick0 - t0) >= 62, 1);

        // Press accepted in HOLD must not fire after switching to STEP
        mode = 2'b10;
        t0 = 0;
        while (cur_mode != 2'b10 && t0 < 20) begin
            @(negedge clk);
            t0++;
        end
        check_eq("step2_commit", cur_mode, 2);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (cpu_ce) n++;
            if (k == 15) step_btn = 1'b0;
        end
        check_eq("stale_press", n, 0);
        repeat (12) @(negedge clk);

        // Reset in the middle of a step pulse
        step_btn = 1'b1;
        t0 = 0;
        while (!cpu_ce && t0 < 15) begin
            @(negedge clk);
            t0++;
        end
        check_eq("rstp_pulse_seen", cpu_ce, 1);
        #1 rst = 1'b1;
        mode = 2'b00;
        step_btn = 1'b0;
        #1;
        check_eq("rstp_cpu_clk", cpu_clk, 0);
        check_eq("rstp_cpu_ce", cpu_ce, 0);
        check_eq("rstp_clkdiv", clkdiv, 0);
        check_eq("rstp_tick", ch_tick, 0);
        check_eq("rstp_mode", cur_mode, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_mode", cur_mode, 0);
        t0 = 0;
        while (!cpu_ce && t0 < 8) begin
            @(negedge clk);
            t0++;
        end
        check_eq("post_rst_ce", cpu_ce, 1);
        check_eq("post_rst_ce_lat", clkdiv, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/clk_gen_multi.md
Name: clk_gen_multi

Overview:
- Parametrised clock-enable generator. Successor to the fixed two-speed CPU clock divider.
- Provides a free-running divide counter, N_CH independently tap-selectable tick channels, and a CPU clock with four modes: fast, slow, debounced single-step, and hold.
- Mode switches are glitch-free: they commit only at CPU clock phase boundaries.
- Sits at the top of the MSOC design; drives the CPU clock/enable, display scan and peripheral timing.

Parameters:
- CNT_W, 32, width of the free-running divide counter.
- N_CH, 4, number of programmable tick channels.
- FAST_TAP, 2, counter bit driving the CPU clock in FAST mode.
- SLOW_TAP, 24, counter bit driving the CPU clock in SLOW mode.
- DB_LEN, 1000000, clk cycles step_btn must be stable before it is accepted.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  requested CPU clock mode: 00 FAST, 01 SLOW, 10 STEP, 11 HOLD. Asynchronous input.
- step_btn  in  1  raw step push-button, asynchronous and bouncy.
- ch_sel  in  N_CH*6  per-channel tap index; channel i uses bits [6i+5:6i].
- clkdiv  out  CNT_W  free-running counter.
- ch_tick  out  N_CH  one-cycle tick pulse per channel.
- cpu_clk  out  1  registered CPU clock level.
- cpu_ce  out  1  one-cycle pulse, coincident with the first cycle cpu_clk is high.
- cur_mode  out  2  currently committed mode.

Behaviour:
- Reset is asynchronous, active-high, on clock clk. While rst is high:
  - clkdiv=0, ch_tick=0, cpu_clk=0, cpu_ce=0, cur_mode=FAST.
  - Synchronisers, debouncer, pending-mode register and step state are all cleared.
- Reset mid-operation truncates any CPU high phase or step pulse immediately; there is no completion after release.
- clkdiv:
  - Increments by 1 every clk and wraps from 2^CNT_W-1 to 0.
  - First increment occurs on the first clk edge after rst deasserts.
- Tap event for tap t: clkdiv[t]=1 and clkdiv[t-1:0]=0 (for t=0, clkdiv[0]=1). Period is 2^(t+1) cycles.
- ch_tick[i]:
  - Registered; high for exactly one cycle, in the cycle after clkdiv holds the tap event for ch_sel[i].
  - ch_sel is sampled every cycle.
  - A tap index >= CNT_W never ticks.
- mode and step_btn each pass through a 2-flop synchroniser (2-cycle latency).
- Mode FSM, with states FAST, SLOW, STEP and HOLD:
  - A synchronised mode that differs from cur_mode becomes pending.
  - The pending mode commits in the first cycle with cpu_clk=0.
  - A later request overwrites an uncommitted pending one.
- FAST / SLOW operation:
  - After entering (or after reset), cpu_clk stays low until the first rising edge of clkdiv[tap], so a partial high phase is never emitted.
  - After that, cpu_clk is a registered copy of clkdiv[tap]: 50% duty, period 2^(tap+1).
- STEP operation:
  - The debouncer updates its level only after the synchronised input has been stable for DB_LEN consecutive cycles.
  - Each 0->1 transition of the debounced level while idle starts one pulse: cpu_clk high for 2^FAST_TAP cycles, with cpu_ce on the first of them.
  - Presses arriving during a pulse are ignored, as are presses that complete in any other mode.
  - A mode change requested mid-pulse waits for the pulse to end.
- HOLD: cpu_clk=0 and cpu_ce=0; clkdiv and ch_tick keep running.
- cpu_ce:
  - High only in the first cycle of each cpu_clk high phase.
  - Never asserted twice within one high phase.

Decomposition:
- Shared package:
  - Mode encodings MODE_FAST/MODE_SLOW/MODE_STEP/MODE_HOLD (2-bit).
  - TAP_IDX_W=6.
  - A tap-event function (counter, tap -> bit).
- One sub-module: btn_debounce, containing the synchroniser, DB_LEN stability counter, debounced level and rising-edge pulse output. It can be reused for the other board buttons.
- The top level holds the counter, channel ticks, mode FSM and CPU clock generation.

Test Plan (sim params: CNT_W=8, N_CH=2, FAST_TAP=1, SLOW_TAP=4, DB_LEN=4):
- Release rst with mode=00 -> clkdiv 0,1,2,… and wraps 255->0; cpu_clk 2 cycles high / 2 low; cpu_ce once every 4 cycles; cur_mode=00.
- ch_sel ch0=3, ch1=9 -> ch_tick[0] one-cycle pulse every 16 cycles, the cycle after clkdiv=8,24,40,…; ch_tick[1] never asserts.
- Switch mode 00->01 while cpu_clk is high -> cur_mode changes only after cpu_clk falls; the first SLOW high phase is a full 16 cycles; no runt pulse.
- STEP mode:
  - 2-cycle step_btn glitch -> no cpu_ce.
  - 10-cycle press -> exactly one cpu_ce and cpu_clk high for 2 cycles.
  - A second press during that pulse -> ignored.
- mode=11 for 1000 cycles -> cpu_clk=0 and cpu_ce=0 throughout, while clkdiv and ch_tick continue.
- Assert rst mid step-pulse -> cpu_clk, cpu_ce and clkdiv are 0 in the same cycle, with no clk edge required; cur_mode=00 after release.
